// File: rtl/uart_fifo_pkg.sv
// Shared UART FIFO definitions: full-policy modes, default sizes
// and the per-cycle operation code used by the FIFO control.
package uart_fifo_pkg;

   localparam int FIFO_MODE_OVERWRITE = 1;
   localparam int FIFO_MODE_REJECT    = 0;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_ADDR_BITS  = 4;

   typedef enum logic [3:0] {
      OP_IDLE,
      OP_FLUSH,
      OP_PUSH,
      OP_PUSHU,
      OP_POP,
      OP_XFER,
      OP_OVWR,
      OP_DROP,
      OP_UFLW
   } fifo_op_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port word array: synchronous write, asynchronous read.
// Ports: clock, we/waddr/wdata (write), raddr -> rdata (read).
module uart_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 4
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised FWFT byte FIFO between UART engines and the datapath.
// Ports: clock/reset, flush, wr_en/wr_data, rd_en, clear_errors;
// rd_data (head), empty/full/almost_*, level, sticky overflow/underflow.
module uart_fifo_param
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_BITS  = FIFO_ADDR_BITS,
   parameter int OVERWRITE  = FIFO_MODE_OVERWRITE,
   parameter int AF_LEVEL   = (2**ADDR_BITS) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  clear_errors,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_BITS:0]    level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int LW = ADDR_BITS + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(2**ADDR_BITS);
   localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);
   localparam bit OVW = (OVERWRITE == FIFO_MODE_OVERWRITE);

   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   fifo_op_t             op;
   logic                 ram_we;
   logic                 rd_inc;
   logic                 ovf_evt;
   logic                 udf_evt;

   assign empty        = (level == '0);
   assign full         = (level == DEPTH_L);
   assign almost_empty = (level <= AE_L);
   assign almost_full  = (level >= AF_L);

   // Items are kept mutually exclusive so flush priority is explicit.
   always_comb begin
      op = OP_IDLE;
      unique case (1'b1)
         flush:
            op = OP_FLUSH;
         !flush && wr_en && rd_en:
            op = empty ? OP_PUSHU : OP_XFER;
         !flush && wr_en && !rd_en:
            op = !full ? OP_PUSH : (OVW ? OP_OVWR : OP_DROP);
         !flush && !wr_en && rd_en:
            op = empty ? OP_UFLW : OP_POP;
         default:
            op = OP_IDLE;
      endcase
   end

   assign ram_we  = (op == OP_PUSH) || (op == OP_PUSHU) ||
                    (op == OP_XFER) || (op == OP_OVWR);
   assign rd_inc  = (op == OP_POP) || (op == OP_XFER) ||
                    (op == OP_OVWR);
   assign ovf_evt = (op == OP_OVWR) || (op == OP_DROP);
   assign udf_evt = (op == OP_UFLW) || (op == OP_PUSHU);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (op == OP_FLUSH) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (ram_we) wr_ptr <= wr_ptr + 1'b1;
         if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
         if (op == OP_PUSH || op == OP_PUSHU)
            level <= level + 1'b1;
         else if (op == OP_POP)
            level <= level - 1'b1;
      end
   end

   // A fresh error in the clearing cycle keeps the flag set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt)           overflow  <= 1'b1;
         else if (clear_errors) overflow  <= 1'b0;
         if (udf_evt)           underflow <= 1'b1;
         else if (clear_errors) underflow <= 1'b0;
      end
   end

   uart_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: overwrite and reject instances, a
// scoreboard queue per instance checked by a negedge pop monitor.
module tb_uart_fifo_param;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic       a_flush = 0, a_wr_en = 0, a_rd_en = 0, a_clear = 0;
   logic [7:0] a_wr_data = 0, a_rd_data;
   logic       a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
   logic [4:0] a_level;

   logic       b_flush = 0, b_wr_en = 0, b_rd_en = 0, b_clear = 0;
   logic [7:0] b_wr_data = 0, b_rd_data;
   logic       b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
   logic [4:0] b_level;

   logic [7:0] qa [$];
   logic [7:0] qb [$];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   uart_fifo_param #(.OVERWRITE(1)) dut_a (
      .clock(clock), .reset(reset), .flush(a_flush),
      .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
      .clear_errors(a_clear), .rd_data(a_rd_data),
      .empty(a_empty), .full(a_full), .almost_empty(a_ae),
      .almost_full(a_af), .level(a_level),
      .overflow(a_ovf), .underflow(a_udf)
   );

   uart_fifo_param #(.OVERWRITE(0)) dut_b (
      .clock(clock), .reset(reset), .flush(b_flush),
      .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
      .clear_errors(b_clear), .rd_data(b_rd_data),
      .empty(b_empty), .full(b_full), .almost_empty(b_ae),
      .almost_full(b_af), .level(b_level),
      .overflow(b_ovf), .underflow(b_udf)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int s, input logic w, input logic [7:0] d,
                       input logic r, input logic f = 0,
                       input logic c = 0);
      a_wr_en = (s == 0) && w; a_wr_data = (s == 0) ? d : 8'h0;
      a_rd_en = (s == 0) && r; a_flush = (s == 0) && f;
      a_clear = (s == 0) && c;
      b_wr_en = (s == 1) && w; b_wr_data = (s == 1) ? d : 8'h0;
      b_rd_en = (s == 1) && r; b_flush = (s == 1) && f;
      b_clear = (s == 1) && c;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      a_wr_en = 0; a_rd_en = 0; a_flush = 0; a_clear = 0;
      b_wr_en = 0; b_rd_en = 0; b_flush = 0; b_clear = 0;
   endtask

   // Monitor: a word is consumed at the edge following a pop request
   // on a non-empty FIFO, so the head seen now is the popped word.
   always @(negedge clock) begin
      if (!reset && a_rd_en && !a_flush && !a_empty) begin
         if (qa.size() == 0) chk("a_unexpected_pop", 1, 0);
         else chk("a_rd_data", int'(a_rd_data), int'(qa.pop_front()));
      end
      if (!reset && b_rd_en && !b_flush && !b_empty) begin
         if (qb.size() == 0) chk("b_unexpected_pop", 1, 0);
         else chk("b_rd_data", int'(b_rd_data), int'(qb.pop_front()));
      end
   end

   initial begin
      #3;
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_level", a_level, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_udf", a_udf, 0);
      @(negedge clock);
      reset = 0;

      // Basic FWFT write then pop
      qa.push_back(8'h11); step(0, 1, 8'h11, 0);
      chk("fwft_first", a_rd_data, 8'h11);
      qa.push_back(8'h22); step(0, 1, 8'h22, 0);
      qa.push_back(8'h33); step(0, 1, 8'h33, 0);
      chk("level3", a_level, 3);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h0, 1);
      chk("drain_empty", a_empty, 1);
      chk("drain_level", a_level, 0);

      // Fill one at a time with threshold checks, then overwrite
      for (int i = 0; i < 16; i++) begin
         qa.push_back(8'(i)); step(0, 1, 8'(i), 0);
         chk("lvl_fill", a_level, i + 1);
         chk("ae_fill", a_ae, int'((i + 1) <= 2));
         chk("af_fill", a_af, int'((i + 1) >= 14));
      end
      void'(qa.pop_front()); qa.push_back(8'h10);
      step(0, 1, 8'h10, 0);
      chk("ow_full", a_full, 1);
      chk("ow_level", a_level, 16);
      chk("ow_ovf", a_ovf, 1);
      chk("ow_head", a_rd_data, 8'h01);
      for (int i = 0; i < 16; i++) step(0, 0, 8'h0, 1);
      chk("ow_drained", a_empty, 1);

      // Simultaneous read/write at empty and at full
      qa.push_back(8'hA1); step(0, 1, 8'hA1, 1);
      chk("sim_e_level", a_level, 1);
      chk("sim_e_udf", a_udf, 1);
      chk("sim_e_head", a_rd_data, 8'hA1);
      step(0, 0, 8'h0, 0, 0, 1);
      chk("clr_ovf", a_ovf, 0);
      chk("clr_udf", a_udf, 0);
      for (int i = 0; i < 15; i++) begin
         qa.push_back(8'hB0 + 8'(i)); step(0, 1, 8'hB0 + 8'(i), 0);
      end
      chk("sim_f_full", a_full, 1);
      qa.push_back(8'hC0); step(0, 1, 8'hC0, 1);
      chk("sim_f_level", a_level, 16);
      chk("sim_f_ovf", a_ovf, 0);
      chk("sim_f_head", a_rd_data, 8'hB0);
      for (int i = 0; i < 16; i++) step(0, 0, 8'h0, 1);
      chk("sim_drained", a_empty, 1);

      // Flush at level 9 with a concurrent write
      for (int i = 0; i < 9; i++) begin
         qa.push_back(8'hD0 + 8'(i)); step(0, 1, 8'hD0 + 8'(i), 0);
      end
      chk("pre_flush_lvl", a_level, 9);
      step(0, 1, 8'hEE, 0, 1);
      qa.delete();
      chk("flush_level", a_level, 0);
      chk("flush_empty", a_empty, 1);
      step(0, 0, 8'h0, 1, 0, 1);
      chk("udf_wins_clr", a_udf, 1);
      qa.push_back(8'h77); step(0, 1, 8'h77, 0);
      chk("post_flush_hd", a_rd_data, 8'h77);
      chk("post_flush_lv", a_level, 1);

      // Asynchronous reset mid-burst
      step(0, 0, 8'h0, 1);
      for (int i = 0; i < 3; i++) begin
         qa.push_back(8'hE0 + 8'(i)); step(0, 1, 8'hE0 + 8'(i), 0);
      end
      a_wr_en = 1; a_wr_data = 8'hE3;
      @(posedge clock);
      #2;
      reset = 1;
      qa.delete();
      #1;
      chk("arst_level", a_level, 0);
      chk("arst_empty", a_empty, 1);
      chk("arst_full", a_full, 0);
      chk("arst_ae", a_ae, 1);
      chk("arst_af", a_af, 0);
      chk("arst_udf", a_udf, 0);
      idle_inputs();
      @(negedge clock);
      reset = 0;
      qa.push_back(8'h5A); step(0, 1, 8'h5A, 0);
      chk("arst_post_hd", a_rd_data, 8'h5A);
      chk("arst_post_lv", a_level, 1);
      step(0, 0, 8'h0, 1);

      // Reject-new policy
      for (int i = 0; i < 16; i++) begin
         qb.push_back(8'(i)); step(1, 1, 8'(i), 0);
      end
      step(1, 1, 8'h10, 0);
      chk("rj_ovf", b_ovf, 1);
      chk("rj_level", b_level, 16);
      chk("rj_full", b_full, 1);
      chk("rj_head", b_rd_data, 8'h00);
      for (int i = 0; i < 16; i++) step(1, 0, 8'h0, 1);
      chk("rj_drained", b_empty, 1);

      idle_inputs();
      @(posedge clock);
      #1;
      chk("qa_leftover", qa.size(), 0);
      chk("qb_leftover", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
